// File: rtl/seg_char_decoder.sv
// seg_char_decoder: turns received UART bytes into a right-entering digit buffer
// for a 7-segment scan driver.
//   MODE=0: ASCII hex digits, '.', BS, ESC, CR, LF
//   MODE=1: raw bytes, two hex nibbles per byte
//   COMMIT_ON_CR=1 (MODE=0 only): outputs change only when a CR is accepted
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx_data_valid    byte valid; accepted on its rising edge
//   rx_data_out      received byte
//   seg_data         digit nibbles, [3:0] is the rightmost (newest) digit
//   data_en, dp_en   per-digit enable / decimal point, bit 0 is rightmost
//   digit_cnt        enabled digits in the working buffer (saturates at DIGITS)
//   err, commit      one-cycle pulses: rejected byte / accepted CR
module seg_char_decoder #(
   parameter int DIGITS       = 8,
   parameter int MODE         = 0,
   parameter int COMMIT_ON_CR = 0,
   localparam int CntW        = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_data_valid,
   input  logic [7:0]            rx_data_out,
   output logic [4*DIGITS-1:0]   seg_data,
   output logic [DIGITS-1:0]     data_en,
   output logic [DIGITS-1:0]     dp_en,
   output logic [CntW-1:0]       digit_cnt,
   output logic                  err,
   output logic                  commit
);

   localparam logic [CntW-1:0] CntMax = CntW'(DIGITS);

   logic                r_valid_q;
   logic [4*DIGITS-1:0] r_seg;
   logic [DIGITS-1:0]   r_en;
   logic [DIGITS-1:0]   r_dp;
   logic [CntW-1:0]     r_cnt;
   logic                r_err;
   logic                r_commit;

   logic                w_acc;
   logic                w_is_digit;
   logic                w_is_letter;
   logic [3:0]          w_nib;
   logic [4*DIGITS-1:0] w_seg_d;
   logic [DIGITS-1:0]   w_en_d;
   logic [DIGITS-1:0]   w_dp_d;
   logic [CntW-1:0]     w_cnt_d;
   logic                w_err_d;
   logic                w_commit_d;

   assign w_acc = rx_data_valid & ~r_valid_q;

   // Letters: 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
   assign w_is_digit  = (rx_data_out >= 8'h30) && (rx_data_out <= 8'h39);
   assign w_is_letter = ((rx_data_out >= 8'h41) && (rx_data_out <= 8'h46)) ||
                        ((rx_data_out >= 8'h61) && (rx_data_out <= 8'h66));
   assign w_nib       = w_is_digit ? rx_data_out[3:0] : rx_data_out[3:0] + 4'd9;

   always_comb begin
      w_seg_d    = r_seg;
      w_en_d     = r_en;
      w_dp_d     = r_dp;
      w_cnt_d    = r_cnt;
      w_err_d    = 1'b0;
      w_commit_d = 1'b0;
      if (w_acc) begin
         if (MODE == 1) begin
            w_seg_d      = r_seg << 8;
            w_seg_d[7:0] = rx_data_out;
            w_en_d       = r_en << 2;
            w_en_d[1:0]  = 2'b11;
            w_dp_d       = r_dp << 2;
            w_cnt_d      = (r_cnt >= CntMax - CntW'(2)) ? CntMax : r_cnt + CntW'(2);
         end else begin
            case (rx_data_out)
               8'h2E: begin
                  if (r_en[0]) w_dp_d[0] = 1'b1;
                  else         w_err_d   = 1'b1;
               end
               8'h08: begin
                  if (r_cnt == '0) begin
                     w_err_d = 1'b1;
                  end else begin
                     w_seg_d = r_seg >> 4;
                     w_en_d  = r_en >> 1;
                     w_dp_d  = r_dp >> 1;
                     w_cnt_d = r_cnt - CntW'(1);
                  end
               end
               8'h1B: begin
                  w_seg_d = '0;
                  w_en_d  = '0;
                  w_dp_d  = '0;
                  w_cnt_d = '0;
               end
               8'h0D: w_commit_d = 1'b1;
               8'h0A: ;
               default: begin
                  if (w_is_digit || w_is_letter) begin
                     w_seg_d      = r_seg << 4;
                     w_seg_d[3:0] = w_nib;
                     w_en_d       = r_en << 1;
                     w_en_d[0]    = 1'b1;
                     w_dp_d       = r_dp << 1;
                     w_cnt_d      = (r_cnt == CntMax) ? CntMax : r_cnt + CntW'(1);
                  end else begin
                     w_err_d = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_q <= 1'b0;
         r_seg     <= '0;
         r_en      <= '0;
         r_dp      <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_commit  <= 1'b0;
      end else begin
         r_valid_q <= rx_data_valid;
         r_seg     <= w_seg_d;
         r_en      <= w_en_d;
         r_dp      <= w_dp_d;
         r_cnt     <= w_cnt_d;
         r_err     <= w_err_d;
         r_commit  <= w_commit_d;
      end
   end

   assign digit_cnt = r_cnt;
   assign err       = r_err;
   assign commit    = r_commit;

   if ((COMMIT_ON_CR != 0) && (MODE == 0)) begin : g_committed
      logic [4*DIGITS-1:0] r_out_seg;
      logic [DIGITS-1:0]   r_out_en;
      logic [DIGITS-1:0]   r_out_dp;

      // CR leaves the working buffer untouched, so the current one is what gets shown.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_out_seg <= '0;
            r_out_en  <= '0;
            r_out_dp  <= '0;
         end else if (w_commit_d) begin
            r_out_seg <= r_seg;
            r_out_en  <= r_en;
            r_out_dp  <= r_dp;
         end
      end

      assign seg_data = r_out_seg;
      assign data_en  = r_out_en;
      assign dp_en    = r_out_dp;
   end else begin : g_direct
      assign seg_data = r_seg;
      assign data_en  = r_en;
      assign dp_en    = r_dp;
   end

endmodule

// File: tb/tb_seg_char_decoder.sv
// tb_seg_char_decoder: scoreboard bench for seg_char_decoder. Three instances
// (ASCII direct, ASCII commit-on-CR, raw byte) are exercised one after another.
// A digit-list reference model pushes expected outputs per byte; a monitor pops
// and compares one cycle after each detected valid rise.
module tb_seg_char_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [1:0] phase = 2'd0;

   logic [31:0] seg_o [3];
   logic [7:0]  en_o  [3];
   logic [7:0]  dp_o  [3];
   logic [3:0]  cnt_o [3];
   logic        err_o [3];
   logic        com_o [3];

   logic [31:0] seg_s;
   logic [7:0]  en_s, dp_s;
   logic [3:0]  cnt_s;
   logic        err_s, com_s;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_char_decoder #(.DIGITS(8), .MODE(0), .COMMIT_ON_CR(0)) u_dut_a (
      .clk(clk), .rst(rst), .rx_data_valid(rx_valid && phase == 2'd0),
      .rx_data_out(rx_data), .seg_data(seg_o[0]), .data_en(en_o[0]), .dp_en(dp_o[0]),
      .digit_cnt(cnt_o[0]), .err(err_o[0]), .commit(com_o[0]));
   seg_char_decoder #(.DIGITS(8), .MODE(0), .COMMIT_ON_CR(1)) u_dut_b (
      .clk(clk), .rst(rst), .rx_data_valid(rx_valid && phase == 2'd1),
      .rx_data_out(rx_data), .seg_data(seg_o[1]), .data_en(en_o[1]), .dp_en(dp_o[1]),
      .digit_cnt(cnt_o[1]), .err(err_o[1]), .commit(com_o[1]));
   seg_char_decoder #(.DIGITS(8), .MODE(1), .COMMIT_ON_CR(0)) u_dut_c (
      .clk(clk), .rst(rst), .rx_data_valid(rx_valid && phase == 2'd2),
      .rx_data_out(rx_data), .seg_data(seg_o[2]), .data_en(en_o[2]), .dp_en(dp_o[2]),
      .digit_cnt(cnt_o[2]), .err(err_o[2]), .commit(com_o[2]));

   always_comb begin
      seg_s = seg_o[0]; en_s = en_o[0]; dp_s = dp_o[0];
      cnt_s = cnt_o[0]; err_s = err_o[0]; com_s = com_o[0];
      case (phase)
         2'd1: begin
            seg_s = seg_o[1]; en_s = en_o[1]; dp_s = dp_o[1];
            cnt_s = cnt_o[1]; err_s = err_o[1]; com_s = com_o[1];
         end
         2'd2: begin
            seg_s = seg_o[2]; en_s = en_o[2]; dp_s = dp_o[2];
            cnt_s = cnt_o[2]; err_s = err_o[2]; com_s = com_o[2];
         end
         default: ;
      endcase
   end

   // ---------------- reference model ----------------
   typedef struct { int nib; bit dp; } dig_t;
   typedef struct { logic [31:0] seg; logic [7:0] en; logic [7:0] dp;
                    logic [3:0] cnt; logic err; logic com; } exp_t;

   dig_t digs[$];   // digs[0] is the newest (rightmost) digit
   exp_t exp_q[$];
   int   m_mode = 0;
   int   m_cor  = 0;
   logic [31:0] shown_seg = '0;
   logic [7:0]  shown_en = '0, shown_dp = '0;

   task automatic render(output logic [31:0] s, output logic [7:0] e, output logic [7:0] d);
      s = '0; e = '0; d = '0;
      for (int i = 0; i < digs.size(); i++) begin
         s = s | (32'(digs[i].nib) << (4 * i));
         e[i] = 1'b1;
         d[i] = digs[i].dp;
      end
   endtask

   task automatic add_digit(input int v);
      dig_t x;
      x.nib = v; x.dp = 1'b0;
      digs.push_front(x);
      if (digs.size() > 8) digs.delete(digs.size() - 1);
   endtask

   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      logic [31:0] s;
      logic [7:0] en, dp;
      int c;
      e.err = 1'b0; e.com = 1'b0;
      c = int'(b);
      if (m_mode == 1) begin
         add_digit(c / 16);
         add_digit(c % 16);
      end else if (c >= "0" && c <= "9") add_digit(c - "0");
      else if (c >= "A" && c <= "F") add_digit(c - "A" + 10);
      else if (c >= "a" && c <= "f") add_digit(c - "a" + 10);
      else if (c == 46) begin
         if (digs.size() > 0) digs[0].dp = 1'b1;
         else e.err = 1'b1;
      end else if (c == 8) begin
         if (digs.size() == 0) e.err = 1'b1;
         else digs.delete(0);
      end else if (c == 27) digs.delete();
      else if (c == 13) e.com = 1'b1;
      else if (c != 10) e.err = 1'b1;
      render(s, en, dp);
      if (m_mode == 0 && m_cor != 0) begin
         if (e.com) begin shown_seg = s; shown_en = en; shown_dp = dp; end
      end else begin
         shown_seg = s; shown_en = en; shown_dp = dp;
      end
      e.seg = shown_seg; e.en = shown_en; e.dp = shown_dp; e.cnt = 4'(digs.size());
      exp_q.push_back(e);
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   logic mon_vq, mon_acc;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_vq  <= 1'b0;
         mon_acc <= 1'b0;
      end else begin
         mon_acc <= rx_valid & ~mon_vq;
         mon_vq  <= rx_valid;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (mon_acc) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_accept", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_seg", 64'(seg_s), 64'(e.seg));
               check("sb_en", 64'(en_s), 64'(e.en));
               check("sb_dp", 64'(dp_s), 64'(e.dp));
               check("sb_cnt", 64'(cnt_s), 64'(e.cnt));
               check("sb_err", 64'(err_s), 64'(e.err));
               check("sb_commit", 64'(com_s), 64'(e.com));
            end
         end else begin
            check("err_idle", 64'(err_s), 64'd0);
            check("commit_idle", 64'(com_s), 64'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data  = b;
      rx_valid = 1'b1;
      model_byte(b);
      repeat (hold) @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1);
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check({name, "_seg"}, 64'(seg_s), 64'd0);
      check({name, "_en"}, 64'(en_s), 64'd0);
      check({name, "_dp"}, 64'(dp_s), 64'd0);
      check({name, "_cnt"}, 64'(cnt_s), 64'd0);
      check({name, "_err"}, 64'(err_s), 64'd0);
      digs.delete();
      shown_seg = '0; shown_en = '0; shown_dp = '0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic random_run(input int n);
      logic [7:0] pool [24];
      string p;
      p = "0123456789ABCDEFabcf.G";
      for (int i = 0; i < 22; i++) pool[i] = p[i];
      pool[22] = 8'h08;
      pool[23] = 8'h1B;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0: send_byte(8'($urandom), $urandom_range(1, 3));
            1: send_byte(8'h0D, 1);
            2: send_byte(8'h0A, 1);
            default: send_byte(pool[$urandom_range(0, 23)], $urandom_range(1, 3));
         endcase
      end
   endtask

   initial begin
      @(negedge clk);
      // ASCII, direct outputs
      phase = 2'd0; m_mode = 0; m_cor = 0;
      do_reset("reset_a");
      send_str("1234");
      check("p1234_seg", 64'(seg_s), 64'h0000_1234);
      check("p1234_en", 64'(en_s), 64'h0F);
      check("p1234_cnt", 64'(cnt_s), 64'd4);
      send_byte(8'h1B, 1);
      send_str("12.5");
      check("pdot_seg", 64'(seg_s[11:0]), 64'h125);
      check("pdot_dp", 64'(dp_s), 64'h02);
      send_byte(8'h08, 1);
      check("pbs_seg", 64'(seg_s[7:0]), 64'h12);
      check("pbs_dp", 64'(dp_s), 64'h01);
      check("pbs_cnt", 64'(cnt_s), 64'd2);
      send_byte(8'h1B, 1);
      send_str("123456789A");
      check("pfull_seg", 64'(seg_s), 64'h3456_789A);
      check("pfull_en", 64'(en_s), 64'hFF);
      check("pfull_cnt", 64'(cnt_s), 64'd8);
      send_byte(8'h1B, 1);
      check("pesc_seg", 64'(seg_s), 64'd0);
      check("pesc_en", 64'(en_s), 64'd0);
      send_byte("G", 1);
      send_byte(".", 1);
      send_byte(8'h08, 1);
      check("perr_seg", 64'(seg_s), 64'd0);
      check("perr_cnt", 64'(cnt_s), 64'd0);
      send_str("98");
      do_reset("midline_a");
      send_str("7");
      check("after_rst_seg", 64'(seg_s), 64'h7);
      random_run(150);

      // ASCII, commit on CR
      phase = 2'd1; m_mode = 0; m_cor = 1;
      do_reset("reset_b");
      send_str("42");
      check("pcor_seg_hold", 64'(seg_s), 64'd0);
      check("pcor_cnt", 64'(cnt_s), 64'd2);
      send_byte(8'h0D, 1);
      check("pcor_seg", 64'(seg_s), 64'h42);
      check("pcor_en", 64'(en_s), 64'h03);
      random_run(150);

      // Raw bytes
      phase = 2'd2; m_mode = 1; m_cor = 0;
      do_reset("reset_c");
      send_byte(8'hAB, 1);
      send_byte(8'hCD, 1);
      check("praw_seg", 64'(seg_s), 64'h0000_ABCD);
      check("praw_en", 64'(en_s), 64'h0F);
      send_byte(8'h12, 5);
      check("phold_seg", 64'(seg_s), 64'h00AB_CD12);
      check("phold_cnt", 64'(cnt_s), 64'd6);
      random_run(100);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg_char_decoder.md
# seg_char_decoder

Parametrised decoder between the UART receiver and the 7-segment scan driver. It turns received bytes into a right-entering, shift-style digit buffer of DIGITS nibbles, with per-digit enables and decimal points. It supports two input modes: ASCII characters with line-editing controls, or raw packed-hex bytes. An optional commit-on-CR double buffer lets a whole line be typed before the display changes.

## Interface
Parameters:
- DIGITS, 8, number of display digits (2..16); must be even when MODE=1
- MODE, 0, 0 = ASCII characters, 1 = raw byte (two hex nibbles per byte)
- COMMIT_ON_CR, 0, 0 = outputs follow every accepted byte; 1 = outputs update only on CR (ASCII mode only; ignored when MODE=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data_valid  in  1  receiver byte-valid; a byte is accepted on its 0->1 transition (sampled by clk)
- rx_data_out  in  8  received byte; must be stable in the cycle where rx_data_valid rises
- seg_data  out  4*DIGITS  digit nibbles; [3:0] is the rightmost (newest) digit
- data_en  out  DIGITS  per-digit display enable; bit 0 is the rightmost digit
- dp_en  out  DIGITS  per-digit decimal point
- digit_cnt  out  $clog2(DIGITS+1)  number of enabled digits, saturates at DIGITS
- err  out  1  one-cycle pulse for a rejected byte
- commit  out  1  one-cycle pulse when a CR is accepted (ASCII mode)

## Operation
Byte acceptance:
- A registered copy of rx_data_valid detects the rising edge; accept = valid & ~valid_q.
- Holding valid high counts as one byte. Two bytes need at least one low cycle between them.

Working buffer:
- Consists of W_seg, W_en and W_dp, plus the count.

MODE=0 byte decoding:
- '0'-'9' give 0-9; 'A'-'F' and 'a'-'f' give 10-15. The working buffer shifts left one digit, the new nibble enters digit 0, a 1 enters en[0] and a 0 enters dp[0]. The oldest digit is discarded. The count increments, saturating at DIGITS.
- '.' (0x2E) sets dp[0] if en[0]=1; otherwise it produces an err pulse. A repeated '.' is idempotent.
- BS (0x08) shifts seg, en and dp right one digit, with zero fill at the MSD, and decrements the count. BS with count 0 produces an err pulse and no change.
- ESC (0x1B) clears seg, en, dp and the count.
- CR (0x0D) pulses commit. With COMMIT_ON_CR=1, it also copies the working buffer to the outputs. The working buffer is kept; it is not cleared.
- LF (0x0A) is ignored silently.
- Any other byte produces an err pulse and no change.

MODE=1 byte decoding:
- Every byte is valid. Shift left two digits: byte[7:4] goes to digit 1 and byte[3:0] goes to digit 0. en[1:0] becomes 2'b11 and dp[1:0] becomes 2'b00.
- The count increases by 2, saturating at DIGITS.
- err and commit stay 0.

Outputs:
- When COMMIT_ON_CR=0 (or MODE=1), the outputs are the working buffer.
- digit_cnt always reflects the working buffer.

## Timing
- Reset (asynchronous, active-high): valid_q, all buffers, seg_data, data_en, dp_en, digit_cnt, err and commit are 0.
- Latency: the byte is sampled at the clk edge where the rise is first seen. The working buffer, the direct outputs, err and commit are updated at that same edge, so they are visible one cycle after valid rises.
- The committed outputs load at the same edge as the commit pulse.
- err and commit are high for exactly one cycle per accepted byte.
- Maximum rate: one byte every 2 clk cycles.
- Reset asserted mid-line discards the partial line. The first rise of valid after reset release is accepted.
- Count saturation: when already full, a digit entry still shifts and the count remains DIGITS.

## Test plan
- MODE=0, DIGITS=8, send "1234" -> seg_data=32'h0000_1234, data_en=8'h0F, digit_cnt=4, no err pulse.
- MODE=0, send "12.5", then BS -> before BS: seg_data[11:0]=12'h125, dp_en=8'h02; after BS: seg_data[7:0]=8'h12, dp_en=8'h01, digit_cnt=2.
- MODE=0, send "123456789A" -> seg_data=32'h3456_789A, data_en=8'hFF, digit_cnt=8. Then ESC -> all outputs 0.
- MODE=0, send 'G', '.' on empty buffer, and BS on empty buffer -> three err pulses, outputs unchanged at 0.
- COMMIT_ON_CR=1, send "42" -> seg_data stays 0 while digit_cnt=2. Send CR -> commit pulse, seg_data=32'h42, data_en=8'h03.
- MODE=1, DIGITS=8, send bytes 8'hAB then 8'hCD -> seg_data=32'h0000_ABCD, data_en=8'h0F. Hold valid high 5 cycles with 8'h12 -> exactly one shift, giving seg_data=32'h00AB_CD12.
